// File: rtl/unary_frame_serializer_if.sv
// Count-in / bit-out handshake bundle for unary_frame_serializer.
// master = count source and bit sink, slave = the serializer.
interface unary_frame_serializer_if #(
  parameter int CW = 7
);
  logic [CW-1:0] in_count;
  logic          in_valid;
  logic          in_ready;
  logic          out_bit;
  logic          out_valid;
  logic          out_ready;
  logic          out_first;
  logic          out_last;
  logic          busy;
  logic          err;

  modport master (
    output in_count, in_valid, out_ready,
    input  in_ready, out_bit, out_valid, out_first, out_last, busy, err
  );

  modport slave (
    input  in_count, in_valid, out_ready,
    output in_ready, out_bit, out_valid, out_first, out_last, busy, err
  );
endinterface

// File: rtl/unary_frame_serializer.sv
// Turns a ones count N into a WIDTH-bit thermometer frame, one bit per handshake.
// Define UNARY_SELFCHECK_EN to re-count each emitted frame and raise a sticky err.
module unary_frame_serializer #(
  parameter int WIDTH = 127,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input logic                     clk,
  input logic                     rst,
  unary_frame_serializer_if.slave bus
);

  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
  localparam logic [CW-1:0] LAST_C  = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] idx_q;
  logic [CW-1:0] cnt_d;
  logic          emit;
  logic          last;
  logic          hs;
  logic          accept;

  assign emit   = (state_q == EMIT);
  assign last   = emit && (idx_q == LAST_C);
  assign hs     = emit && bus.out_ready;
  // A new count is taken either from IDLE or on the final handshake of a frame.
  assign bus.in_ready = emit ? (last && bus.out_ready) : 1'b1;
  assign accept = bus.in_valid && bus.in_ready;
  assign cnt_d  = (bus.in_count > WIDTH_C) ? WIDTH_C : bus.in_count;

  assign bus.out_valid = emit;
  assign bus.out_bit   = emit && (idx_q < cnt_q);
  assign bus.out_first = emit && (idx_q == '0);
  assign bus.out_last  = last;
  assign bus.busy      = emit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else if (accept) begin
      state_q <= EMIT;
      cnt_q   <= cnt_d;
      idx_q   <= '0;
    end else if (hs) begin
      if (last) begin
        state_q <= IDLE;
      end else begin
        idx_q <= idx_q + CW'(1);
      end
    end
  end

`ifdef UNARY_SELFCHECK_EN
  logic [CW-1:0] ones_q;
  logic          err_q;

  // Accumulates the bit actually presented on the port, so a corrupted output is caught.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        ones_q <= '0;
      end else if (hs) begin
        ones_q <= ones_q + CW'(bus.out_bit);
      end
      if (hs && last && ((ones_q + CW'(bus.out_bit)) != cnt_q)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_unary_frame_serializer.sv
// Self-checking bench for unary_frame_serializer: table vectors, random frames
// against a thermometer model, back-to-back, mid-frame reset and self-check corners.
module tb_unary_frame_serializer;

  localparam int WIDTH = 127;
  localparam int CW    = 7;

  typedef logic [WIDTH-1:0] frame_t;

  typedef struct {
    int   cnt;
    int   exp_ones;
    logic exp_b0;
    logic exp_blast;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests  = 0;
  int   failed = 0;
  vec_t vecs[5];

  always #5 clk = ~clk;

  unary_frame_serializer_if #(.CW(CW)) u_if ();

  unary_frame_serializer #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  // Reference frame: the first min(n, WIDTH) positions are one, the rest zero.
  function automatic frame_t model(input int n);
    frame_t f;
    int     k;
    k = (n > WIDTH) ? WIDTH : n;
    f = '0;
    for (int i = 0; i < k; i++) f[i] = 1'b1;
    return f;
  endfunction

  task automatic check(input string name, input logic [WIDTH:0] act, input logic [WIDTH:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("[TB] ok %s", name);
    end
  endtask

  // Presents a count from IDLE and leaves the bench at the negedge showing bit 0.
  task automatic start(input int n);
    @(negedge clk);
    u_if.in_count = CW'(n);
    u_if.in_valid = 1'b1;
    #1;
    check("idle in_ready", u_if.in_ready, 1);
    @(negedge clk);
    u_if.in_valid = 1'b0;
    #1;
    check("bit0 valid/first/busy", {u_if.out_valid, u_if.out_first, u_if.busy}, 3'b111);
  endtask

  // Collects frame bits on handshakes, checking flags and in_ready each cycle.
  task automatic capture(input int pct, input int max_hs, output frame_t bits,
                         output int nhs, output int flag_err);
    int cyc;
    bit done;
    cyc = 0;
    done = 0;
    bits = '0;
    nhs = 0;
    flag_err = 0;
    while (!done) begin
      u_if.out_ready = ($urandom_range(99) < pct);
      #1;
      if (!u_if.out_valid || !u_if.busy) flag_err++;
      if (u_if.out_first !== (nhs == 0)) flag_err++;
      if (u_if.out_last !== (nhs == WIDTH - 1)) flag_err++;
      if (u_if.in_ready !== ((nhs == WIDTH - 1) && u_if.out_ready)) flag_err++;
      if (u_if.out_ready) begin
        bits[nhs] = u_if.out_bit;
        nhs++;
      end
      if (nhs == WIDTH || nhs == max_hs) done = 1;
      cyc++;
      if (cyc > 3000) begin
        flag_err++;
        done = 1;
      end
      @(negedge clk);
    end
    u_if.out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t bits;
    int     nhs;
    int     fe;
    int     n;

    vecs[0] = '{cnt: 0,   exp_ones: 0,   exp_b0: 1'b0, exp_blast: 1'b0};
    vecs[1] = '{cnt: 127, exp_ones: 127, exp_b0: 1'b1, exp_blast: 1'b1};
    vecs[2] = '{cnt: 5,   exp_ones: 5,   exp_b0: 1'b1, exp_blast: 1'b0};
    vecs[3] = '{cnt: 1,   exp_ones: 1,   exp_b0: 1'b1, exp_blast: 1'b0};
    vecs[4] = '{cnt: 126, exp_ones: 126, exp_b0: 1'b1, exp_blast: 1'b0};

    u_if.in_count  = '0;
    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset outputs",
          {u_if.in_ready, u_if.out_valid, u_if.out_bit, u_if.out_first,
           u_if.out_last, u_if.busy, u_if.err}, 7'b1000000);
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      start(vecs[v].cnt);
      capture(100, WIDTH, bits, nhs, fe);
      $display("[TB] table count=%0d handshakes=%0d ones=%0d", vecs[v].cnt, nhs, $countones(bits));
      check("table ones", $countones(bits), vecs[v].exp_ones);
      check("table bit0/bitlast", {bits[0], bits[WIDTH-1]}, {vecs[v].exp_b0, vecs[v].exp_blast});
      check("table frame", bits, model(vecs[v].cnt));
      check("table flags", fe, 0);
      #1;
      check("table idle after", {u_if.in_ready, u_if.out_valid, u_if.busy, u_if.err}, 4'b1000);
    end

    start(64);
    capture(50, WIDTH, bits, nhs, fe);
    $display("[TB] count=64 ready 50%% handshakes=%0d", nhs);
    check("stall frame 64", bits, model(64));
    check("stall flags", fe, 0);

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(WIDTH);
      start(n);
      capture($urandom_range(100, 30), WIDTH, bits, nhs, fe);
      $display("[TB] random count=%0d handshakes=%0d", n, nhs);
      check("random frame", bits, model(n));
      check("random flags", fe, 0);
    end

    // Back-to-back: in_valid stays high across the frame boundary.
    @(negedge clk);
    u_if.in_count = CW'(3);
    u_if.in_valid = 1'b1;
    @(negedge clk);
    u_if.in_count = CW'(100);
    capture(100, WIDTH, bits, nhs, fe);
    #1;
    check("b2b no bubble", {u_if.out_valid, u_if.out_first, u_if.busy}, 3'b111);
    u_if.in_valid = 1'b0;
    check("b2b frame 3", bits, model(3));
    check("b2b flags 3", fe, 0);
    capture(100, WIDTH, bits, nhs, fe);
    check("b2b frame 100", bits, model(100));
    check("b2b flags 100", fe, 0);

    // Reset in the middle of a count-90 frame, at bit 40.
    start(90);
    capture(100, 40, bits, nhs, fe);
    check("partial 90 bits", bits, model(40));
    rst = 1'b1;
    #1;
    check("async reset outputs",
          {u_if.in_ready, u_if.out_valid, u_if.out_bit, u_if.out_first,
           u_if.out_last, u_if.busy, u_if.err}, 7'b1000000);
    @(negedge clk);
    rst = 1'b0;
    start(2);
    capture(100, WIDTH, bits, nhs, fe);
    check("post-reset frame 2", bits, model(2));
    check("post-reset flags", fe, 0);

`ifdef UNARY_SELFCHECK_EN
    start(10);
    for (int k = 0; k < WIDTH; k++) begin
      u_if.out_ready = 1'b1;
      if (k == 3) force u_if.out_bit = 1'b0;
      else release u_if.out_bit;
      @(negedge clk);
    end
    release u_if.out_bit;
    u_if.out_ready = 1'b0;
    #1;
    check("selfcheck err set", u_if.err, 1);
    repeat (4) @(negedge clk);
    check("selfcheck err sticky", u_if.err, 1);
    rst = 1'b1;
    #1;
    check("selfcheck err cleared", u_if.err, 0);
    @(negedge clk);
    rst = 1'b0;
`else
    check("err tied low", u_if.err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
